// File: rtl/rect_fill_framebuffer.sv
// Palette-indexed framebuffer with a rectangle-fill writer and a 3-stage
// scan-out pipeline that upscales WIDTHxHEIGHT to 640x480 by pixel replication.
module rect_fill_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int XW     = 8,
    parameter int YW     = 7
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y0,
    input  logic [YW-1:0] cmd_y1,
    input  logic [3:0]    cmd_color,
    output logic          busy,
    output logic          done,
    input  logic          pal_we,
    input  logic [3:0]    pal_idx,
    input  logic [23:0]   pal_rgb,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue
);

    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int XS = 640 / WIDTH;
    localparam int YS = 480 / HEIGHT;
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d, xa_q, xa_d, xb_q, xb_d;
    logic [YW-1:0] cy_q, cy_d, yb_q, yb_d;
    logic [3:0]    color_q, color_d;
    logic          done_q, done_d;
    logic          fb_we;

    // Normalised and clamped command rectangle.
    logic [XW-1:0] xa_c, xb_raw, xb_c;
    logic [YW-1:0] ya_c, yb_raw, yb_c;
    logic          empty_c;

    always_comb begin
        xa_c    = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        xb_raw  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        ya_c    = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        yb_raw  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        xb_c    = (xb_raw > XMAX) ? XMAX : xb_raw;
        yb_c    = (yb_raw > YMAX) ? YMAX : yb_raw;
        empty_c = (xa_c > XMAX) || (ya_c > YMAX);
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        color_d = color_q;
        done_d  = 1'b0;
        fb_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (empty_c) begin
                        done_d = 1'b1;
                    end else begin
                        cx_d    = xa_c;
                        cy_d    = ya_c;
                        xa_d    = xa_c;
                        xb_d    = xb_c;
                        yb_d    = yb_c;
                        color_d = cmd_color;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // An asserted reset aborts the write scheduled for this edge.
                fb_we = reset;
                if (cx_q == xb_q) begin
                    cx_d = xa_q;
                    if (cy_q == yb_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            color_q <= color_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == FILL);
    assign done      = done_q;

    // Framebuffer: one write port for the filler, one registered read port for scan-out.
    logic [3:0]    fb_mem [WIDTH*HEIGHT];
    logic [AW-1:0] wr_addr, rd_addr;

    assign wr_addr = AW'(cy_q) * AW'(WIDTH) + AW'(cx_q);

    always_ff @(posedge CLOCK_50) begin
        if (fb_we) begin
            fb_mem[wr_addr] <= color_q;
        end
    end

    // Palette lives in flops so it can be reloaded on reset.
    logic [23:0] pal_q [16];

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= (i == 15) ? 24'hFFFFFF : 24'h000000;
            end
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_rgb;
        end
    end

    // Read pipeline: coordinate scale, framebuffer read, palette lookup.
    logic [XW-1:0] fx_q, fx_d;
    logic [YW-1:0] fy_q, fy_d;
    logic          v1_q, v1_d, v2_q;
    logic [3:0]    idx_q;
    logic [23:0]   rgb_q;
    logic [9:0]    fx_full;
    logic [8:0]    fy_full;

    always_comb begin
        fx_full = x / 10'(XS);
        fy_full = y / 9'(YS);
        v1_d    = (x < 10'd640) && (y < 9'd480);
        // Out-of-screen coordinates read address 0 so the index stays in range.
        fx_d    = v1_d ? XW'(fx_full) : '0;
        fy_d    = v1_d ? YW'(fy_full) : '0;
    end

    assign rd_addr = AW'(fy_q) * AW'(WIDTH) + AW'(fx_q);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            fx_q  <= '0;
            fy_q  <= '0;
            v1_q  <= 1'b0;
            idx_q <= '0;
            v2_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            fx_q  <= fx_d;
            fy_q  <= fy_d;
            v1_q  <= v1_d;
            idx_q <= fb_mem[rd_addr];
            v2_q  <= v1_q;
            rgb_q <= v2_q ? pal_q[idx_q] : 24'h000000;
        end
    end

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];

endmodule
